// File: rtl/custom_vec_wr_unit.sv
// rtl/custom_vec_wr_unit.sv - streams memory word reads into consecutive custom vector store slots
// Optional base-address alignment check: CUSTOM_VEC_WR_ALIGN_CHECK_EN
module custom_vec_wr_unit #(
    parameter int NUM_WORDS       = 512,
    parameter int WORD_W          = 64,
    parameter int ADDR_W          = 64,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDX_W          = $clog2(NUM_WORDS),
    localparam int LEN_W          = IDX_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_base_addr_i,
    input  logic [IDX_W-1:0]  cmd_vidx_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [WORD_W-1:0] mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    output logic              vrf_we_o,
    output logic [IDX_W-1:0]  vrf_waddr_o,
    output logic [WORD_W-1:0] vrf_wdata_o,
    output logic              done_valid_o,
    output logic              done_err_o,
    output logic              busy_o
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  slot;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  out_next;
    logic              err_flag;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_bad;

    // Responses with nothing in flight are stale (e.g. from before a reset) and are dropped.
    assign rsp_take        = mem_rsp_valid_i && (outstanding != '0);
    assign rsp_bad         = rsp_take && mem_rsp_err_i;
    assign mem_req_valid_o = (state == S_ISSUE) && (outstanding < MAX_OUT) && !rsp_bad;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;
    assign mem_req_addr_o  = addr;
    assign cmd_ready_o     = (state == S_IDLE);
    assign busy_o          = (state != S_IDLE);
    assign done_valid_o    = (state == S_DONE);
    assign done_err_o      = (state == S_DONE) && err_flag;

    always_comb begin
        out_next = outstanding;
        if (req_fire && !rsp_take) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!req_fire && rsp_take) begin
            out_next = outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            addr        <= '0;
            slot        <= '0;
            len         <= '0;
            issued      <= '0;
            outstanding <= '0;
            err_flag    <= 1'b0;
            vrf_we_o    <= 1'b0;
            vrf_waddr_o <= '0;
            vrf_wdata_o <= '0;
        end else begin
            outstanding <= out_next;
            vrf_we_o    <= 1'b0;

            if (rsp_take) begin
                if (mem_rsp_err_i) begin
                    err_flag <= 1'b1;
                end else if (!err_flag) begin
                    vrf_we_o    <= 1'b1;
                    vrf_waddr_o <= slot;
                    vrf_wdata_o <= mem_rsp_data_i;
                    slot        <= slot + IDX_W'(1);
                end
            end

            if (req_fire) begin
                addr   <= addr + ADDR_W'(8);
                issued <= issued + LEN_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr     <= cmd_base_addr_i;
                        slot     <= cmd_vidx_i;
                        len      <= cmd_len_i;
                        issued   <= '0;
                        err_flag <= 1'b0;
`ifdef CUSTOM_VEC_WR_ALIGN_CHECK_EN
                        if (cmd_base_addr_i[2:0] != 3'b000) begin
                            err_flag <= 1'b1;
                            state    <= S_DONE;
                        end else if (cmd_len_i == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
`else
                        if (cmd_len_i == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    // An error response ends issuing; skip DRAIN if nothing is left in flight.
                    if (rsp_bad) begin
                        state <= (out_next == '0) ? S_DONE : S_DRAIN;
                    end else if (req_fire && (issued + LEN_W'(1) == len)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_next == '0) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_custom_vec_wr_unit.sv
// tb/tb_custom_vec_wr_unit.sv - randomized self-checking bench with a memory model and reference expectations
module tb_custom_vec_wr_unit;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_base = '0;
    logic [8:0]  cmd_vidx = '0;
    logic [9:0]  cmd_len = '0;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        vrf_we;
    logic [8:0]  vrf_waddr;
    logic [63:0] vrf_wdata;
    logic        done_valid;
    logic        done_err;
    logic        busy;

    custom_vec_wr_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_base_addr_i (cmd_base),
        .cmd_vidx_i      (cmd_vidx),
        .cmd_len_i       (cmd_len),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_err_i   (mem_rsp_err),
        .vrf_we_o        (vrf_we),
        .vrf_waddr_o     (vrf_waddr),
        .vrf_wdata_o     (vrf_wdata),
        .done_valid_o    (done_valid),
        .done_err_o      (done_err),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model state
    logic        ready_en = 1'b1;
    logic        ready_rnd = 1'b1;
    logic        rand_ready = 1'b0;
    logic        mem_hold = 1'b0;
    int          dly_max = 0;
    int          rsp_idx = 0;
    int          err_idx = -1;
    logic [63:0] pend_a[$];
    int          pend_t[$];
    assign mem_req_ready = ready_en && ready_rnd;

    // observation logs
    logic [63:0] req_a[$];
    int          req_c[$];
    int          wr_s[$];
    logic [63:0] wr_d[$];
    int          wr_c[$];
    int          outs = 0;
    int          max_outs = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic        done_err_seen = 1'b0;
    logic        done_prev = 1'b0;
    logic        rdy_after_done = 1'b0;
    int          err_cyc = -1;

    logic [63:0] cur_base;
    int          cur_vidx;
    int          cur_len;

    function automatic logic [63:0] mdata(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_1234, a[63:32] + a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = '0;
        if (pend_a.size() > 0 && !mem_hold && cyc >= pend_t[0]) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mdata(pend_a[0]);
            mem_rsp_err   = (rsp_idx == err_idx);
            rsp_idx++;
            void'(pend_a.pop_front());
            void'(pend_t.pop_front());
        end
        ready_rnd = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            outs = 0;
            done_prev = 1'b0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                req_a.push_back(mem_req_addr);
                req_c.push_back(cyc);
                pend_a.push_back(mem_req_addr);
                pend_t.push_back(cyc + 1 + $urandom_range(0, dly_max));
                outs++;
            end
            if (mem_rsp_valid && outs > 0) begin
                outs--;
                if (mem_rsp_err && err_cyc < 0) err_cyc = cyc;
            end
            if (outs > max_outs) max_outs = outs;
            if (vrf_we) begin
                wr_s.push_back(int'(vrf_waddr));
                wr_d.push_back(vrf_wdata);
                wr_c.push_back(cyc);
            end
            if (done_prev) rdy_after_done = cmd_ready;
            if (done_valid) begin
                done_cnt++;
                done_cyc = cyc;
                done_err_seen = done_err;
            end
            done_prev = done_valid;
        end
    end

    task automatic start_cmd(input logic [63:0] base, input int vidx, input int len,
                             input int eidx, output int t);
        int guard = 0;
        while ((pend_a.size() != 0 || !cmd_ready) && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        #2;
        req_a.delete(); req_c.delete(); wr_s.delete(); wr_d.delete(); wr_c.delete();
        rsp_idx = 0; err_idx = eidx; max_outs = 0; done_cnt = 0; done_cyc = -1;
        done_err_seen = 1'b0; rdy_after_done = 1'b0; err_cyc = -1;
        cur_base = base; cur_vidx = vidx; cur_len = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_vidx  = 9'(vidx);
        cmd_len   = 10'(len);
        @(negedge clk);
        t = cyc;
        chk("cmd_ready_at_hs", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int t);
        int   guard = 0;
        int   g;
        logic exp_err;
        logic misaligned = 1'b0;
        while (done_cnt == 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (4) @(posedge clk);
        g = (err_idx < 0 || err_idx >= cur_len) ? cur_len : err_idx;
        exp_err = (g < cur_len);
`ifdef CUSTOM_VEC_WR_ALIGN_CHECK_EN
        if (cur_base[2:0] != 3'b000) begin
            misaligned = 1'b1;
            g = 0;
            exp_err = 1'b1;
        end
`endif
        chk("done_cnt", done_cnt, 1);
        chk("done_err", done_err_seen, exp_err);
        chk("wr_cnt", wr_s.size(), g);
        for (int k = 0; k < wr_s.size() && k < g; k++) begin
            chk("wr_slot", wr_s[k], (cur_vidx + k) % 512);
            chk("wr_data", wr_d[k], mdata(cur_base + 64'(8 * k)));
        end
        if (misaligned) begin
            chk("req_cnt_misaligned", req_a.size(), 0);
        end else if (!exp_err) begin
            chk("req_cnt", req_a.size(), cur_len);
        end else begin
            chk("req_min", req_a.size() >= g + 1, 1);
            chk("req_max", req_a.size() <= g + MAXO, 1);
            chk("no_req_after_err", req_c.size() == 0 || req_c[$] < err_cyc, 1);
        end
        for (int k = 0; k < req_a.size(); k++) begin
            chk("req_addr", req_a[k], cur_base + 64'(8 * k));
        end
        chk("max_outstanding", max_outs <= MAXO, 1);
        chk("outstanding_end", outs, 0);
        chk("ready_after_done", rdy_after_done, 1);
        if (g == cur_len && cur_len > 0 && wr_c.size() > 0) chk("done_with_last_wr", done_cyc, wr_c[$]);
        if (cur_len == 0 || misaligned) chk("done_at_t1", done_cyc, t + 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int len;
        int eidx;
        int guard;

        @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_vrf_we", vrf_we, 0);
        chk("rst_vrf_waddr", vrf_waddr, 0);
        chk("rst_vrf_wdata", vrf_wdata, 0);
        chk("rst_done", {done_valid, done_err}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // zero-wait memory, back-to-back requests
        start_cmd(64'h1000_0000, 0, 4, -1, t);
        finish_cmd(t);
        for (int k = 0; k < 4 && k < req_c.size(); k++) chk("b2b_req_cycle", req_c[k], t + 1 + k);

        // slot wrap
        start_cmd(64'h2000_0000, 510, 4, -1, t);
        finish_cmd(t);

        // withheld responses: outstanding limit
        mem_hold = 1'b1;
        start_cmd(64'h3000_0100, 0, 8, -1, t);
        repeat (20) @(posedge clk);
        chk("hold_req_cnt", req_a.size(), MAXO);
        @(negedge clk);
        chk("hold_req_valid", mem_req_valid, 0);
        mem_hold = 1'b0;
        finish_cmd(t);

        // error on third response
        start_cmd(64'h3000_0000, 0, 6, 2, t);
        finish_cmd(t);

        // zero length
        start_cmd(64'h3000_0800, 5, 0, -1, t);
        finish_cmd(t);

        // minimum latency
        start_cmd(64'h0000_0040, 9, 1, -1, t);
        finish_cmd(t);
        if (req_c.size() > 0) chk("lat_req", req_c[0], t + 1);
        if (wr_c.size() > 0) chk("lat_wr", wr_c[0], t + 3);
        chk("lat_done", done_cyc, t + 3);

        // reset mid-issue with two reads in flight
        mem_hold = 1'b1;
        start_cmd(64'h4000_0000, 7, 8, -1, t);
        guard = 0;
        while (req_a.size() < 2 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        #1;
        ready_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req_cnt", req_a.size(), 2);
        chk("mid_rst_req_valid", mem_req_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_done", done_valid, 0);
        chk("mid_rst_we", vrf_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_en = 1'b1;
        mem_hold = 1'b0;
        guard = 0;
        while (pend_a.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        chk("late_rsp_no_wr", wr_s.size(), 0);
        chk("late_rsp_no_done", done_cnt, 0);
        start_cmd(64'h5000_0000, 100, 1, -1, t);
        finish_cmd(t);

        // misaligned base
        start_cmd(64'h1000_0004, 0, 4, -1, t);
        finish_cmd(t);
`ifdef CUSTOM_VEC_WR_ALIGN_CHECK_EN
        chk("align_no_req", req_a.size(), 0);
`else
        if (req_a.size() > 0) chk("unaligned_passthru", req_a[0], 64'h1000_0004);
`endif

        // randomized commands
        for (int i = 0; i < 30; i++) begin
            dly_max    = $urandom_range(0, 3);
            rand_ready = 1'($urandom_range(0, 1));
            len        = $urandom_range(0, 24);
            eidx       = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            start_cmd({$urandom, $urandom} & ~64'h7, $urandom_range(0, 511), len, eidx, t);
            finish_cmd(t);
        end
        dly_max = 0;
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
